// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Holds the FSM state type, func3 access-size codes and controller strobe polarities.
// No logic; imported by lsu and lsu_align.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  // func3 access size / sign codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Controller strobes that are asserted low
  localparam logic CS_ACTIVE = 1'b0;
  localparam logic WE_ACTIVE = 1'b0;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store data replication, byte enables, legality, load extract/extend.
// Latency: purely combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports: is_store/func3/addr_lo/store_data -> ok/wdata/be (request side);
//        ld_func3/ld_off/rdata -> ld_data (response side, driven from latched fields).
module lsu_align
  import lsu_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  func3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  output logic        ok,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  input  logic [2:0]  ld_func3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Request side: func3 legality, alignment, and lane steering for stores.
  always_comb begin
    ok    = 1'b0;
    wdata = store_data;
    be    = 4'b1111;
    case (func3)
      F3_B: begin
        ok = 1'b1;
        if (is_store) begin
          wdata = {4{store_data[7:0]}};
          be    = 4'b0001 << addr_lo;
        end
      end
      F3_H: begin
        ok = ~addr_lo[0];
        if (is_store) begin
          wdata = {2{store_data[15:0]}};
          be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        end
      end
      F3_W:    ok = (addr_lo == 2'b00);
      // Unsigned variants exist only for loads
      F3_BU:   ok = ~is_store;
      F3_HU:   ok = ~is_store & ~addr_lo[0];
      default: ok = 1'b0;
    endcase
  end

  // Response side: pick the addressed lane from the full word and extend it.
  assign ld_byte = rdata[{ld_off, 3'b000} +: 8];
  assign ld_half = ld_off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    case (ld_func3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_BU:   ld_data = {24'b0, ld_byte};
      F3_HU:   ld_data = {16'b0, ld_half};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: decodes controller strobes, runs a req/ready access to data memory.
// Latency: decode cycle + BUSY until mem_ready (>=1) + one DONE cycle; timeout after WAIT_MAX.
// Backpressure: stall held to the core while decoding a valid access and throughout BUSY.
// Ports: cs/rd_en/wr_en/func3/addr/store_data from decode; stall/load_data/acc_fault/bus_err
//        to the core; mem_req/we/addr/wdata/be registered to memory, mem_ready/rdata back.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        acc_fault,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        mem_req_q, mem_we_q, bus_err_q;
  logic [31:0] mem_addr_q, mem_wdata_q, load_data_q;
  logic [3:0]  mem_be_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;

  logic        mem_op, is_st, is_ld, acc_ok, acc_valid, acc_bad, tmo;
  logic [31:0] st_wdata, ld_fmt;
  logic [3:0]  st_be;

  // Nothing is decoded while held in reset, so stall drops with rst_n.
  assign mem_op    = rst_n && (state_q == ST_IDLE) && (cs == CS_ACTIVE);
  assign is_st     = mem_op && (wr_en == WE_ACTIVE);
  assign is_ld     = mem_op && (wr_en != WE_ACTIVE) && rd_en;
  assign acc_valid = (is_st || is_ld) && acc_ok;
  assign acc_bad   = (is_st || is_ld) && !acc_ok;

  assign cnt_d = cnt_q + 32'd1;
  assign tmo   = (WAIT_MAX != 0) && (cnt_d == WAIT_MAX);

  lsu_align u_align (
    .is_store   (is_st),
    .func3      (func3),
    .addr_lo    (addr[1:0]),
    .store_data (store_data),
    .ok         (acc_ok),
    .wdata      (st_wdata),
    .be         (st_be),
    .ld_func3   (f3_q),
    .ld_off     (off_q),
    .rdata      (mem_rdata),
    .ld_data    (ld_fmt)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state; ready takes precedence over a coincident timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (acc_valid) state_d = ST_BUSY;
      ST_BUSY: if (mem_ready || tmo) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: stall and fault are combinational from the controller inputs
  always_comb begin
    stall     = 1'b0;
    acc_fault = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stall     = acc_valid;
        acc_fault = acc_bad;
      end
      ST_BUSY: stall = 1'b1;
      default: ;
    endcase
  end

  // Request fields, wait counter and load result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      f3_q        <= '0;
      off_q       <= '0;
      load_data_q <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      bus_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (acc_valid) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= is_st;
            mem_addr_q  <= {addr[31:2], 2'b00};
            mem_wdata_q <= st_wdata;
            mem_be_q    <= st_be;
            f3_q        <= func3;
            off_q       <= addr[1:0];
            cnt_q       <= '0;
          end
        end
        ST_BUSY: begin
          if (mem_ready) begin
            mem_req_q   <= 1'b0;
            load_data_q <= mem_we_q ? 32'd0 : ld_fmt;
          end else if (tmo) begin
            mem_req_q   <= 1'b0;
            load_data_q <= '0;
            bus_err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: ;
      endcase
    end
  end

  // A faulting access reports zero without disturbing the held result
  assign load_data = acc_fault ? 32'd0 : load_data_q;
  assign bus_err   = bus_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: timeline model of each access plus literal checkpoints.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench drives mem_ready directly).
module tb_lsu;

  localparam int WM = 16;

  logic        clk = 1'b0;
  logic        rst_n, cs, rd_en, wr_en;
  logic [2:0]  func3;
  logic [31:0] addr, store_data;
  logic        stall, acc_fault, bus_err, mem_req, mem_we, mem_ready;
  logic [31:0] load_data, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  always #5 clk = ~clk;

  lsu #(.WAIT_MAX(WM)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .rd_en(rd_en), .wr_en(wr_en),
    .func3(func3), .addr(addr), .store_data(store_data),
    .stall(stall), .load_data(load_data), .acc_fault(acc_fault), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // ---------------- model: rules of a single access ----------------
  function automatic int unsigned m_sz(input logic [2:0] f3);
    return f3[1] ? 4 : (f3[0] ? 2 : 1);
  endfunction

  function automatic bit m_legal(input bit st, input logic [2:0] f3, input logic [31:0] a);
    bit known;
    if (st) known = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    else    known = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    return known && ((a % m_sz(f3)) == 0);
  endfunction

  function automatic logic [3:0] m_be(input bit st, input logic [2:0] f3, input logic [31:0] a);
    int unsigned m;
    if (!st) return 4'hF;
    m = ((32'd1 << m_sz(f3)) - 32'd1) << (a % 32'd4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
    case (m_sz(f3))
      1:       return (sd & 32'hFF) * 32'h01010101;
      2:       return (sd & 32'hFFFF) * 32'h00010001;
      default: return sd;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * (a % 32'd4));
    if (m_sz(f3) == 1) begin
      v = v & 32'hFF;
      if (!f3[2] && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else if (m_sz(f3) == 2) begin
      v = v & 32'hFFFF;
      if (!f3[2] && v >= 32'h8000) v = v | 32'hFFFF0000;
    end
    return v;
  endfunction

  // ---------------- expected outputs for the current cycle ----------------
  bit          chk_en = 1'b0;
  logic        e_stall, e_req, e_we, e_fault, e_berr;
  logic [31:0] e_ld, e_addr, e_wdata;
  logic [3:0]  e_be;
  logic [31:0] m_ld = 32'd0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", 32'(stall), 32'(e_stall));
      chk("mem_req", 32'(mem_req), 32'(e_req));
      chk("acc_fault", 32'(acc_fault), 32'(e_fault));
      chk("bus_err", 32'(bus_err), 32'(e_berr));
      chk("load_data", load_data, e_ld);
      if (e_req) begin
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_be", 32'(mem_be), 32'(e_be));
        if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
      end
    end
  end

  // ---------------- cycle stepping with observation ----------------
  int          stall_cnt, berr_cnt;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;

  task automatic cyc();
    @(negedge clk);
    if (stall === 1'b1) stall_cnt++;
    if (bus_err === 1'b1) berr_cnt++;
    if (mem_req === 1'b1) begin
      cap_addr  = mem_addr;
      cap_be    = mem_be;
      cap_wdata = mem_wdata;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic release_bus();
    cs = 1'b1; wr_en = 1'b1; rd_en = 1'b0; mem_ready = 1'b0;
  endtask

  // One instruction from decode through DONE plus one idle cycle.
  // rdy_at: BUSY cycle (1 = first mem_req cycle) in which mem_ready is raised; 0 = never.
  task automatic access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input int rdy_at, input logic [31:0] rd);
    bit          tmo;
    int          last;
    logic [31:0] newld;
    stall_cnt = 0; berr_cnt = 0;
    cs = 1'b0; wr_en = !st; rd_en = 1'b1; func3 = f3; addr = a;
    store_data = sd; mem_rdata = rd; mem_ready = 1'b0;
    e_req = 1'b0; e_berr = 1'b0; e_ld = m_ld;
    if (!m_legal(st, f3, a)) begin
      e_stall = 1'b0; e_fault = 1'b1; e_ld = 32'd0;
      cyc();
      release_bus();
      e_fault = 1'b0; e_ld = m_ld;
      cyc();
      return;
    end
    tmo   = !(rdy_at >= 1 && rdy_at <= WM);
    last  = tmo ? WM : rdy_at;
    newld = (st || tmo) ? 32'd0 : m_load(f3, a, rd);
    e_stall = 1'b1; e_fault = 1'b0;
    cyc();
    for (int t = 1; t <= last; t++) begin
      e_req = 1'b1; e_we = st; e_addr = a & 32'hFFFFFFFC;
      e_be = m_be(st, f3, a); e_wdata = m_wdata(f3, sd);
      mem_ready = (t == rdy_at);
      cyc();
    end
    mem_ready = 1'b0;
    e_stall = 1'b0; e_req = 1'b0; e_berr = tmo;
    m_ld = newld; e_ld = newld;
    cyc();
    release_bus();
    e_berr = 1'b0;
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cs = 1'b1; wr_en = 1'b1; rd_en = 1'b0; func3 = 3'd0;
    addr = 32'd0; store_data = 32'd0; mem_ready = 1'b0; mem_rdata = 32'd0;
    e_stall = 0; e_req = 0; e_we = 0; e_fault = 0; e_berr = 0;
    e_ld = 0; e_addr = 0; e_wdata = 0; e_be = 0;
    stall_cnt = 0; berr_cnt = 0; cap_addr = 0; cap_be = 0; cap_wdata = 0;

    #12;
    chk("rst mem_req", 32'(mem_req), 32'd0);
    chk("rst stall", 32'(stall), 32'd0);
    chk("rst load_data", load_data, 32'd0);
    chk("rst acc_fault", 32'(acc_fault), 32'd0);
    chk("rst bus_err", 32'(bus_err), 32'd0);
    chk("rst mem_be", 32'(mem_be), 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    chk("rst mem_we", 32'(mem_we), 32'd0);

    @(posedge clk); #1;
    rst_n = 1'b1; chk_en = 1'b1;
    cyc();

    // No-ops: chip-select inactive with store strobe; selected with no strobe
    cs = 1'b1; wr_en = 1'b0; rd_en = 1'b1; cyc();
    cs = 1'b0; wr_en = 1'b1; rd_en = 1'b0; cyc();
    release_bus(); cyc();

    // SW, ready in the third request cycle
    access(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 3, 32'd0);
    chk("SW stall cycles", 32'(stall_cnt), 32'd4);
    chk("SW mem_be", 32'(cap_be), 32'hF);
    chk("SW mem_wdata", cap_wdata, 32'hDEADBEEF);

    // SB at the top byte lane, minimum latency
    access(1'b1, 3'b000, 32'h103, 32'h000000A5, 1, 32'd0);
    chk("SB mem_addr", cap_addr, 32'h100);
    chk("SB mem_be", 32'(cap_be), 32'h8);
    chk("SB mem_wdata", cap_wdata, 32'hA5A5A5A5);
    chk("SB stall cycles", 32'(stall_cnt), 32'd2);

    // Loads with sign / zero extension
    access(1'b0, 3'b000, 32'h101, 32'd0, 2, 32'h00008000);
    chk("LB data", load_data, 32'hFFFFFF80);
    access(1'b0, 3'b100, 32'h101, 32'd0, 2, 32'h00008000);
    chk("LBU data", load_data, 32'h00000080);
    access(1'b0, 3'b101, 32'h102, 32'd0, 1, 32'hBEEF0000);
    chk("LHU data", load_data, 32'h0000BEEF);
    access(1'b0, 3'b001, 32'h000, 32'd0, 1, 32'h80017FFF);
    chk("LH data", load_data, 32'h00007FFF);

    // SH upper half
    access(1'b1, 3'b001, 32'h102, 32'h1234ABCD, 2, 32'd0);
    chk("SH mem_be", 32'(cap_be), 32'hC);
    chk("SH mem_wdata", cap_wdata, 32'hABCDABCD);

    // Ready arriving in the same cycle the timeout would fire: ready wins
    access(1'b0, 3'b010, 32'h104, 32'd0, WM, 32'hCAFEF00D);
    chk("LW late data", load_data, 32'hCAFEF00D);
    chk("LW late bus_err", 32'(berr_cnt), 32'd0);

    // Faults: misaligned word, unsupported load code, unsigned store code
    access(1'b0, 3'b010, 32'h102, 32'd0, 1, 32'd0);
    chk("LW misalign stall", 32'(stall_cnt), 32'd0);
    access(1'b0, 3'b011, 32'h100, 32'd0, 1, 32'd0);
    access(1'b1, 3'b100, 32'h100, 32'h55, 1, 32'd0);
    chk("fault keeps load_data", load_data, 32'hCAFEF00D);

    // Timeout: memory never answers
    access(1'b0, 3'b010, 32'h200, 32'd0, 0, 32'h12345678);
    chk("TMO stall cycles", 32'(stall_cnt), 32'(WM + 1));
    chk("TMO bus_err pulses", 32'(berr_cnt), 32'd1);
    chk("TMO load_data", load_data, 32'd0);

    // Reset in the middle of an outstanding load
    access(1'b0, 3'b000, 32'h101, 32'd0, 1, 32'h00008000);
    cs = 1'b0; wr_en = 1'b1; rd_en = 1'b1; func3 = 3'b010; addr = 32'h200; mem_ready = 1'b0;
    e_stall = 1'b1; e_req = 1'b0; e_fault = 1'b0; e_berr = 1'b0; e_ld = m_ld;
    cyc();
    e_req = 1'b1; e_we = 1'b0; e_addr = 32'h200; e_be = 4'hF;
    cyc();
    cyc();
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst mem_req", 32'(mem_req), 32'd0);
    chk("midrst stall", 32'(stall), 32'd0);
    chk("midrst load_data", load_data, 32'd0);
    chk("midrst mem_be", 32'(mem_be), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; release_bus();
    m_ld = 32'd0;
    e_stall = 1'b0; e_req = 1'b0; e_fault = 1'b0; e_berr = 1'b0; e_ld = 32'd0;
    chk_en = 1'b1;
    cyc();
    access(1'b0, 3'b010, 32'h300, 32'd0, 2, 32'h11223344);
    chk("post-reset LW data", load_data, 32'h11223344);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
